// File: rtl/sipo_frame_ctrl.sv
// Framing SIPO controller: bit-valid gated shifting, word counting, registered valid/ready output.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit after each WIDTH-bit word.
module sipo_frame_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cont,
    input  logic             d,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err,
    input  logic             clear_flags
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             word_done;
    logic [WIDTH-1:0] word_val;
`ifdef SIPO_PARITY_EN
    logic             par_fail;
`endif

    always_comb begin
        state_next = state;
        sh_next    = sh;
        cnt_next   = cnt;
        word_done  = 1'b0;
        word_val   = {sh[WIDTH-2:0], d};
`ifdef SIPO_PARITY_EN
        par_fail   = 1'b0;
`endif
        if (abort) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = SHIFT;
                        cnt_next   = '0;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        sh_next = {sh[WIDTH-2:0], d};
                        if (cnt == CW'(WIDTH - 1)) begin
                            cnt_next = '0;
`ifdef SIPO_PARITY_EN
                            state_next = PAR;
`else
                            word_done  = 1'b1;
                            state_next = cont ? SHIFT : IDLE;
`endif
                        end else begin
                            cnt_next = cnt + 1'b1;
                        end
                    end
                end
`ifdef SIPO_PARITY_EN
                // Parity bit is checked against the full word already in sh and never shifted in.
                PAR: begin
                    if (bit_valid) begin
                        word_val = sh;
                        if (^{sh, d}) par_fail = 1'b1;
                        else          word_done = 1'b1;
                        state_next = cont ? SHIFT : IDLE;
                    end
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh        <= '0;
            cnt       <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sh  <= sh_next;
            cnt <= cnt_next;
            if (word_done) begin
                if (!out_valid || out_ready) begin
                    out_word  <= word_val;
                    out_valid <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (clear_flags)
                overrun <= 1'b0;
            else if (word_done && out_valid && !out_ready)
                overrun <= 1'b1;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              parity_err <= 1'b0;
        else if (clear_flags) parity_err <= 1'b0;
        else if (par_fail)    parity_err <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed plus randomized bench for sipo_frame_ctrl against a queue-based frame model.
module tb_sipo_frame_ctrl;

    localparam int unsigned WIDTH = 4;
`ifdef SIPO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst, start, abort, cont, d, bit_valid, out_ready, clear_flags;
    logic [WIDTH-1:0] out_word;
    logic out_valid, busy, overrun, parity_err;

    int checks = 0;
    int errors = 0;

    // Reference model: frame-level view, bits collected in a queue.
    bit m_active;
    int m_bits[$];
    int m_word;
    bit m_valid, m_overrun, m_perr;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
        .d(d), .bit_valid(bit_valid), .out_word(out_word), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun),
        .parity_err(parity_err), .clear_flags(clear_flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_bits.delete(); m_word = 0;
        m_valid = 0; m_overrun = 0; m_perr = 0;
    endtask

    task automatic model_step();
        bit done, fail, ov_set;
        int wv, ones;
        done = 0; fail = 0; ov_set = 0; wv = 0; ones = 0;
        if (abort) begin
            m_active = 0;
            m_bits.delete();
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_bits.delete();
            end
        end else if (bit_valid) begin
            m_bits.push_back(int'(d));
            if (m_bits.size() == WIDTH + PB) begin
                for (int i = 0; i < WIDTH; i++) wv = wv * 2 + m_bits[i];
                foreach (m_bits[i]) ones += m_bits[i];
                fail = (PB == 1) && (ones % 2 != 0);
                done = 1;
                m_bits.delete();
                if (!cont) m_active = 0;
            end
        end
        if (done && !fail) begin
            if (!m_valid || out_ready) begin
                m_word = wv;
                m_valid = 1;
            end else begin
                ov_set = 1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (clear_flags) begin
            m_overrun = 0;
            m_perr = 0;
        end else begin
            if (ov_set) m_overrun = 1;
            if (fail) m_perr = 1;
        end
    endtask

    task automatic check_all();
        chk("out_word", 32'(out_word), 32'(m_word));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_active));
        chk("overrun", 32'(overrun), 32'(m_overrun));
        chk("parity_err", 32'(parity_err), 32'(m_perr));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1; d = b;
        step();
        bit_valid = 0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy_last);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1 && PB == 0) out_ready = rdy_last;
            send_bit(w[WIDTH-1-i]);
        end
        if (PB == 1) begin
            out_ready = rdy_last;
            send_bit(^w);
        end
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    task automatic pulse_abort();
        abort = 1; step(); abort = 0;
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; cont = 0; d = 0; bit_valid = 0;
        out_ready = 0; clear_flags = 0;
        model_reset();
        #2;
        chk("rst_word", 32'(out_word), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_flags", 32'({overrun, parity_err}), 32'h0);
        @(negedge clk);
        rst = 0;

        // single word, cont=0
        cont = 0; out_ready = 1;
        pulse_start();
        chk("t1_busy_up", 32'(busy), 32'h1);
        send_word(4'b1011, 1'b1);
        chk("t1_word", 32'(out_word), 32'hb);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_busy_down", 32'(busy), 32'h0);
        step();
        chk("t1_valid_1cyc", 32'(out_valid), 32'h0);

        // overrun with consumer stalled
        cont = 1; out_ready = 0;
        pulse_start();
        send_word(4'b1011, 1'b0);
        send_word(4'b0110, 1'b0);
        chk("t2_word_kept", 32'(out_word), 32'hb);
        chk("t2_valid", 32'(out_valid), 32'h1);
        chk("t2_overrun", 32'(overrun), 32'h1);
        clear_flags = 1; step(); clear_flags = 0;
        chk("t2_cleared", 32'(overrun), 32'h0);
        pulse_abort();
        out_ready = 1; step(); out_ready = 0;

        // same-cycle accept and completion
        cont = 1;
        pulse_start();
        send_word(4'b1011, 1'b0);
        send_word(4'b0110, 1'b1);
        chk("t3_word", 32'(out_word), 32'h6);
        chk("t3_valid", 32'(out_valid), 32'h1);
        chk("t3_no_overrun", 32'(overrun), 32'h0);
        pulse_abort();

        // abort mid-word leaves no residue
        cont = 0; out_ready = 1;
        pulse_start();
        send_bit(1'b1);
        send_bit(1'b1);
        pulse_abort();
        chk("t4_idle", 32'(busy), 32'h0);
        pulse_start();
        send_word(4'b0101, 1'b1);
        chk("t4_word", 32'(out_word), 32'h5);

        // async reset mid-frame with pending word
        cont = 0; out_ready = 0;
        pulse_start();
        send_word(4'b1011, 1'b0);
        pulse_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2 rst = 1;
        #1;
        model_reset();
        chk("t5_word", 32'(out_word), 32'h0);
        chk("t5_valid", 32'(out_valid), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_flags", 32'({overrun, parity_err}), 32'h0);
        @(negedge clk);
        rst = 0;

`ifdef SIPO_PARITY_EN
        cont = 0; out_ready = 1;
        pulse_start();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(1);
        chk("p_good_word", 32'(out_word), 32'hb);
        chk("p_good_valid", 32'(out_valid), 32'h1);
        step();
        pulse_start();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        chk("p_bad_valid", 32'(out_valid), 32'h0);
        chk("p_bad_err", 32'(parity_err), 32'h1);
        clear_flags = 1; step(); clear_flags = 0;
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            start       = ($urandom_range(0, 9) == 0);
            abort       = ($urandom_range(0, 39) == 0);
            cont        = ($urandom_range(0, 1) == 1);
            bit_valid   = ($urandom_range(0, 9) < 7);
            d           = 1'($urandom);
            out_ready   = ($urandom_range(0, 1) == 1);
            clear_flags = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Framing controller for the serial-in/parallel-out shift datapath. Gates shifting with a bit-valid strobe, counts bits into WIDTH-bit words, and presents each completed word on a registered parallel output with a valid/ready handshake. Sits between a serial bit source and a parallel consumer, replacing the free-running SIPO where words must be delimited and flow-controlled.

## Interface
- WIDTH, 4: word length in bits, legal 2..32
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin a frame; honoured only in IDLE
- abort  in  1  drop the partial word and return to IDLE
- cont  in  1  1 = stay in SHIFT after each word; 0 = return to IDLE after one word
- d  in  1  serial data bit
- bit_valid  in  1  d is sampled at this edge
- out_word  out  WIDTH  last completed word
- out_valid  out  1  out_word holds an unconsumed word
- out_ready  in  1  consumer accepts out_word when out_valid=1
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky: a word completed while the previous one was unconsumed
- parity_err  out  1  sticky parity mismatch (see Configuration)
- clear_flags  in  1  synchronous clear of overrun and parity_err

## Operation
- Internal WIDTH-bit shift register `sh` and bit counter `cnt` of width $clog2(WIDTH+1).
- Each sampled bit does `sh <= {sh[WIDTH-2:0], d}`. The first bit of a word lands in the MSB.
- States:
  - IDLE: busy=0, no sampling. start=1 → SHIFT, cnt=0.
  - SHIFT: on bit_valid, shift and increment cnt. When the sampled bit is bit WIDTH-1, the word completes: cnt=0, then → SHIFT if cont=1, else → IDLE. bit_valid=0 holds all state.
  - PAR (only when SIPO_PARITY_EN is defined): entered in place of completion after WIDTH data bits. The next sampled bit is the parity bit, and the word completes on that bit.
- On word completion:
  - If out_valid=0, or out_ready=1 in the same cycle: out_word <= completed word, out_valid <= 1.
  - Otherwise: the new word is dropped, out_word is unchanged, and overrun <= 1.
- out_valid && out_ready with no completion in that cycle: out_valid <= 0. out_word holds its value.
- abort has priority over start, bit_valid and completion: → IDLE, cnt=0, sh unchanged. A pending out_word/out_valid is kept.
- start while not IDLE is ignored.
- clear_flags takes priority over a same-cycle set of overrun or parity_err.

## Timing
- Reset values: state=IDLE, sh=0, cnt=0, out_word=0, out_valid=0, busy=0, overrun=0, parity_err=0.
- All outputs are registered. No combinational path from any input to any output.
- Latency: the edge that samples the last bit (data bit, or parity bit) loads out_word and sets out_valid. Both are visible right after that edge.
- With cont=1 and bit_valid held high: one word every WIDTH cycles (WIDTH+1 with parity), with no gap between words.
- busy rises at the edge where start is sampled. It falls at the completion edge when cont=0, or at the abort edge.
- rst asserted mid-frame clears everything immediately, including pending out_valid. There is no partial-word recovery.

## Configuration
- SIPO_PARITY_EN defined:
  - Each word carries one trailing even-parity bit: XOR of the WIDTH data bits and the parity bit must be 0.
  - On mismatch the word is discarded (no out_valid, no overrun check) and parity_err <= 1. The FSM still follows cont.
  - The parity bit is never shifted into sh.
- SIPO_PARITY_EN undefined: the PAR state is absent, parity_err is tied 0, and words complete after WIDTH bits.

## Test plan
- WIDTH=4, cont=0, out_ready=1: start, then bits 1,0,1,1 on consecutive cycles → out_word=4'b1011, out_valid high for 1 cycle, busy low after the 4th bit.
- cont=1, out_ready=0: stream 1011 then 0110 → out_word stays 4'b1011, out_valid=1, overrun=1. clear_flags → overrun=0.
- cont=1, out_ready=1 in the same cycle the second word completes → out_word=4'b0110, out_valid stays 1, overrun=0.
- abort after 2 bits, then start and bits 0,1,0,1 → out_word=4'b0101, with no contamination from the aborted bits.
- Assert rst after 3 bits with a pending out_valid=1 → all outputs 0 immediately, state IDLE.
- SIPO_PARITY_EN: bits 1,0,1,1 with parity 1 → out_word=4'b1011. Same data with parity 0 → no out_valid, parity_err=1.
